// File: rtl/uart_trig_cmd.sv
// uart_trig_cmd: UART command receiver for the trigger-control path.
//
// Receives 8N1 bytes at one of four selectable bit rates and parses
// 4-byte frames (0x53, channel, type, value) into per-channel trigger
// registers. Malformed frames, bad stop bits and stalled frames pulse
// frame_err. Optional echo path (macro UART_TRIG_ECHO_EN) pushes every
// received byte into a FIFO and replays it on tx.
//
// Ports:
//   clk, nrst (async, active-low)  clock and reset
//   baud[1:0]        rate select, latched at start-bit detection / TX pop
//   rx               serial input, idle high (asynchronous)
//   tx               serial output, idle high
//   trig_val         channel c value at [8c+7:8c]
//   trig_type        channel c type at [2c+1:2c] (2'b11 = disabled)
//   trig_upd         one-cycle pulse on the channel just written
//   rx_byte/rx_valid last received byte and its one-cycle strobe
//   frame_err        parse, stop-bit or timeout error pulse
//   echo_ovf         echo byte dropped because the FIFO was full
//   busy             RX not idle, TX active or FIFO non-empty
module uart_trig_cmd #(
  parameter int N_CH         = 4,
  parameter int DIV0         = 109091,
  parameter int DIV1         = 20000,
  parameter int DIV2         = 5000,
  parameter int DIV3         = 1250,
  parameter int TIMEOUT_BITS = 40,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [1:0]        baud,
  input  logic              rx,
  output logic              tx,
  output logic [N_CH*8-1:0] trig_val,
  output logic [N_CH*2-1:0] trig_type,
  output logic [N_CH-1:0]   trig_upd,
  output logic [7:0]        rx_byte,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              echo_ovf,
  output logic              busy
);

  function automatic logic [19:0] div_sel(input logic [1:0] b);
    case (b)
      2'b00:   return 20'(DIV0);
      2'b01:   return 20'(DIV1);
      2'b10:   return 20'(DIV2);
      default: return 20'(DIV3);
    endcase
  endfunction

  // ---------------- RX ----------------
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  rx_st_t      rx_st_q;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic [19:0] rx_div_q, rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_sh_q, rx_byte_q;
  logic        rx_valid_q, stop_err_q;
  logic        bit_end_d;

  assign bit_end_d = (rx_cnt_q == rx_div_q - 20'd1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= R_IDLE;
      rx_div_q   <= 20'(DIV0);
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_valid_q <= 1'b0;
      stop_err_q <= 1'b0;
      case (rx_st_q)
        R_IDLE: if (rx_prev_q && !rx_s2_q) begin
          rx_div_q <= div_sel(baud);
          rx_cnt_q <= '0;
          rx_st_q  <= R_START;
        end
        // Re-check the line at mid start bit; a short low pulse is a glitch.
        R_START: if (rx_cnt_q == {1'b0, rx_div_q[19:1]}) begin
          rx_cnt_q <= '0;
          rx_bit_q <= '0;
          rx_st_q  <= rx_s2_q ? R_IDLE : R_DATA;
        end else begin
          rx_cnt_q <= rx_cnt_q + 20'd1;
        end
        R_DATA: if (bit_end_d) begin
          rx_cnt_q <= '0;
          rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_q <= R_STOP;
        end else begin
          rx_cnt_q <= rx_cnt_q + 20'd1;
        end
        R_STOP: if (bit_end_d) begin
          if (rx_s2_q) begin
            rx_byte_q  <= rx_sh_q;
            rx_valid_q <= 1'b1;
          end else begin
            stop_err_q <= 1'b1;
          end
          rx_st_q <= R_IDLE;
        end else begin
          rx_cnt_q <= rx_cnt_q + 20'd1;
        end
        default: rx_st_q <= R_IDLE;
      endcase
    end
  end

  // ---------------- Frame parser ----------------
  typedef enum logic [1:0] {P_HUNT, P_CH, P_TYPE, P_VAL} p_st_t;
  p_st_t          p_st_q;
  logic [3:0]     ch_q;
  logic [1:0]     ty_q;
  logic [7:0]     val_q [N_CH];
  logic [1:0]     typ_q [N_CH];
  logic [N_CH-1:0] upd_q;
  logic           ferr_q;
  logic [19:0]    to_cnt_q;
  logic [15:0]    to_bits_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      p_st_q    <= P_HUNT;
      ch_q      <= '0;
      ty_q      <= '0;
      upd_q     <= '0;
      ferr_q    <= 1'b0;
      to_cnt_q  <= '0;
      to_bits_q <= '0;
      for (int c = 0; c < N_CH; c++) begin
        val_q[c] <= '0;
        typ_q[c] <= 2'b11;
      end
    end else begin
      upd_q  <= '0;
      ferr_q <= 1'b0;
      if (stop_err_q) begin
        ferr_q <= 1'b1;
        p_st_q <= P_HUNT;
      end else if (rx_valid_q) begin
        to_cnt_q  <= '0;
        to_bits_q <= '0;
        case (p_st_q)
          P_HUNT: if (rx_byte_q == 8'h53) p_st_q <= P_CH;
          P_CH: if (rx_byte_q < 8'(N_CH)) begin
            ch_q   <= rx_byte_q[3:0];
            p_st_q <= P_TYPE;
          end else begin
            ferr_q <= 1'b1;
            p_st_q <= P_HUNT;
          end
          P_TYPE: if (rx_byte_q <= 8'd2) begin
            ty_q   <= rx_byte_q[1:0];
            p_st_q <= P_VAL;
          end else begin
            ferr_q <= 1'b1;
            p_st_q <= P_HUNT;
          end
          default: begin
            for (int c = 0; c < N_CH; c++) begin
              if (ch_q == 4'(c)) begin
                val_q[c] <= rx_byte_q;
                typ_q[c] <= ty_q;
                upd_q[c] <= 1'b1;
              end
            end
            p_st_q <= P_HUNT;
          end
        endcase
      end else if (p_st_q == P_HUNT) begin
        to_cnt_q  <= '0;
        to_bits_q <= '0;
      end else if (to_bits_q == 16'(TIMEOUT_BITS)) begin
        ferr_q    <= 1'b1;
        p_st_q    <= P_HUNT;
        to_cnt_q  <= '0;
        to_bits_q <= '0;
      end else if (to_cnt_q == rx_div_q - 20'd1) begin
        // Bit periods are measured with the divisor of the last received byte.
        to_cnt_q  <= '0;
        to_bits_q <= to_bits_q + 16'd1;
      end else begin
        to_cnt_q <= to_cnt_q + 20'd1;
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_out
    assign trig_val[8*c +: 8]  = val_q[c];
    assign trig_type[2*c +: 2] = typ_q[c];
  end

  assign trig_upd  = upd_q;
  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = ferr_q;

`ifdef UART_TRIG_ECHO_EN
  // ---------------- Echo FIFO + TX ----------------
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {T_IDLE, T_SEND} tx_st_t;
  tx_st_t      tx_st_q;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic [8:0]  tx_sh_q;
  logic [3:0]  tx_bit_q;
  logic [19:0] tx_div_q, tx_cnt_q;
  logic        tx_q, ovf_q;
  logic        empty_d, full_d, pop_d, push_d;

  assign empty_d = (wp_q == rp_q);
  assign full_d  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop_d   = (tx_st_q == T_IDLE) && !empty_d;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push_d  = rx_valid_q && (!full_d || pop_d);

  always_ff @(posedge clk) begin
    if (push_d) mem_q[wp_q[AW-1:0]] <= rx_byte_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_st_q  <= T_IDLE;
      wp_q     <= '0;
      rp_q     <= '0;
      tx_sh_q  <= '1;
      tx_bit_q <= '0;
      tx_div_q <= 20'(DIV0);
      tx_cnt_q <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= rx_valid_q && full_d && !pop_d;
      if (push_d) wp_q <= wp_q + 1'b1;
      if (pop_d)  rp_q <= rp_q + 1'b1;
      case (tx_st_q)
        T_IDLE: if (pop_d) begin
          tx_sh_q  <= {1'b1, mem_q[rp_q[AW-1:0]]};
          tx_q     <= 1'b0;
          tx_div_q <= div_sel(baud);
          tx_cnt_q <= '0;
          tx_bit_q <= '0;
          tx_st_q  <= T_SEND;
        end
        // tx_bit_q counts bits already started: 1..8 data, 9 stop.
        default: if (tx_cnt_q == tx_div_q - 20'd1) begin
          tx_cnt_q <= '0;
          if (tx_bit_q == 4'd9) begin
            tx_st_q <= T_IDLE;
          end else begin
            tx_q     <= tx_sh_q[0];
            tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
            tx_bit_q <= tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_q <= tx_cnt_q + 20'd1;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign echo_ovf = ovf_q;
  assign busy     = (rx_st_q != R_IDLE) || (tx_st_q != T_IDLE) || !empty_d;
`else
  assign tx       = 1'b1;
  assign echo_ovf = 1'b0;
  assign busy     = (rx_st_q != R_IDLE);
`endif

endmodule

// File: tb/tb_uart_trig_cmd.sv
module tb_uart_trig_cmd;
  localparam int N_CH = 4;
  localparam int D0 = 200, D1 = 40, D2 = 16, D3 = 8;
  localparam int TOB = 40;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic [1:0]        baud = 2'b11;
  logic              rx = 1'b1;
  logic              tx;
  logic [N_CH*8-1:0] trig_val;
  logic [N_CH*2-1:0] trig_type;
  logic [N_CH-1:0]   trig_upd;
  logic [7:0]        rx_byte;
  logic              rx_valid, frame_err, echo_ovf, busy;

  uart_trig_cmd #(
    .N_CH(N_CH), .DIV0(D0), .DIV1(D1), .DIV2(D2), .DIV3(D3),
    .TIMEOUT_BITS(TOB), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .nrst(nrst), .baud(baud), .rx(rx), .tx(tx),
    .trig_val(trig_val), .trig_type(trig_type), .trig_upd(trig_upd),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err),
    .echo_ovf(echo_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int n_rxv = 0, n_ferr = 0, n_upd = 0, n_ovf = 0, n_txlow = 0;
  logic [N_CH-1:0] last_upd = '0;
  logic [7:0] exp_val [N_CH];
  logic [1:0] exp_ty  [N_CH];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_valid) n_rxv++;
    if (frame_err) n_ferr++;
    if (trig_upd != '0) begin n_upd++; last_upd = trig_upd; end
    if (echo_ovf) n_ovf++;
    if (tx !== 1'b1) n_txlow++;
  end

  function automatic int bdiv(input logic [1:0] b);
    case (b)
      2'b00:   return D0;
      2'b01:   return D1;
      2'b10:   return D2;
      default: return D3;
    endcase
  endfunction

  // Frame-level reference: how many bytes the frame consumes, whether it is an
  // error, and which channel (if any) it writes.
  function automatic void model_frame(input logic [7:0] f [4], output int nb,
                                      output int err, output int ch);
    ch = -1; err = 0;
    if (f[0] != 8'h53)          nb = 1;
    else if (f[1] >= 8'(N_CH))  begin nb = 2; err = 1; end
    else if (f[2] > 8'd2)       begin nb = 3; err = 1; end
    else                        begin nb = 4; ch = int'(f[1]); end
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin exp_val[c] = 8'h00; exp_ty[c] = 2'b11; end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [1:0] bd, input logic stopb);
    int d;
    d = bdiv(bd);
    baud = bd;
    @(negedge clk);
    rx = 1'b0;
    repeat (d) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rx = b[i]; repeat (d) @(negedge clk); end
    rx = stopb;
    repeat (d) @(negedge clk);
    rx = 1'b1;
    repeat (d) @(negedge clk);
  endtask

  task automatic check_regs(input string tag);
    for (int c = 0; c < N_CH; c++) begin
      chk($sformatf("%s_val%0d", tag, c), 64'(trig_val[8*c +: 8]), 64'(exp_val[c]));
      chk($sformatf("%s_typ%0d", tag, c), 64'(trig_type[2*c +: 2]), 64'(exp_ty[c]));
    end
  endtask

  task automatic run_frame(input logic [7:0] f [4], input logic [1:0] bd, input string tag);
    int nb, err, ch, r0, e0, u0;
    model_frame(f, nb, err, ch);
    r0 = n_rxv; e0 = n_ferr; u0 = n_upd;
    for (int i = 0; i < nb; i++) send_byte(f[i], bd, 1'b1);
    chk({tag, "_nrx"}, 64'(n_rxv - r0), 64'(nb));
    chk({tag, "_err"}, 64'(n_ferr - e0), 64'(err));
    chk({tag, "_nupd"}, 64'(n_upd - u0), 64'((ch >= 0) ? 1 : 0));
    chk({tag, "_rxb"}, 64'(rx_byte), 64'(f[nb-1]));
    if (ch >= 0) begin
      exp_val[ch] = f[3];
      exp_ty[ch]  = f[2][1:0];
      chk({tag, "_updv"}, 64'(last_upd), 64'(1 << ch));
    end
    check_regs(tag);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_tx"}, 64'(tx), 64'(1));
    chk({tag, "_upd"}, 64'(trig_upd), 64'(0));
    chk({tag, "_rxb"}, 64'(rx_byte), 64'(0));
    chk({tag, "_rxv"}, 64'(rx_valid), 64'(0));
    chk({tag, "_ferr"}, 64'(frame_err), 64'(0));
    chk({tag, "_ovf"}, 64'(echo_ovf), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    check_regs(tag);
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 20000) begin @(negedge clk); t++; end
    chk({tag, "_idle_to"}, 64'(t >= 20000), 64'(0));
  endtask

`ifdef UART_TRIG_ECHO_EN
  task automatic echo_test();
    logic [7:0] eb [10];
    logic [7:0] txq [$];
    int r0, o0;
    for (int k = 0; k < 10; k++) begin
      eb[k] = 8'($urandom_range(0, 255));
      if (eb[k] == 8'h53) eb[k] = 8'h35;
    end
    wait_idle("echo_pre");
    r0 = n_rxv; o0 = n_ovf;
    fork
      begin
        for (int k = 0; k < 10; k++) send_byte(eb[k], 2'b10, 1'b1);
      end
      begin
        // Slow rate selected only around the first pop keeps TX busy.
        int t;
        t = 0;
        while (!rx_valid && t < 5000) begin @(negedge clk); t++; end
        baud = 2'b00;
        repeat (3) @(negedge clk);
        baud = 2'b10;
      end
      begin
        for (int k = 0; k < 9; k++) begin
          int d, t;
          logic [7:0] b;
          d = (k == 0) ? D0 : D2;
          t = 0;
          b = '0;
          while (tx !== 1'b0 && t < 30000) begin @(negedge clk); t++; end
          if (t >= 30000) break;
          repeat (d / 2) @(negedge clk);
          for (int i = 0; i < 8; i++) begin repeat (d) @(negedge clk); b[i] = tx; end
          repeat (d) @(negedge clk);
          txq.push_back(b);
        end
      end
    join
    chk("echo_nrx", 64'(n_rxv - r0), 64'(10));
    chk("echo_ntx", 64'(txq.size()), 64'(9));
    for (int k = 0; k < txq.size() && k < 9; k++)
      chk($sformatf("echo_b%0d", k), 64'(txq[k]), 64'(eb[k]));
    chk("echo_novf", 64'(n_ovf - o0), 64'(1));
    wait_idle("echo_post");
    chk("echo_tx_idle", 64'(tx), 64'(1));
  endtask
`else
  task automatic echo_test();
    int t0, o0;
    t0 = n_txlow; o0 = n_ovf;
    for (int k = 0; k < 3; k++) send_byte(8'($urandom_range(0, 255)) & 8'h0F, 2'b10, 1'b1);
    chk("noecho_tx", 64'(n_txlow - t0), 64'(0));
    chk("noecho_ovf", 64'(n_ovf - o0), 64'(0));
    chk("noecho_busy", 64'(busy), 64'(0));
  endtask
`endif

  initial begin
    logic [7:0] fr [4];
    int r0, e0, u0;
    model_reset();
    repeat (4) @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outs("rst");

    // Directed frames.
    fr = '{8'h53, 8'h02, 8'h01, 8'h7F}; run_frame(fr, 2'b11, "d_ch2");
    fr = '{8'h53, 8'h05, 8'h00, 8'h00}; run_frame(fr, 2'b11, "d_badch");
    fr = '{8'h53, 8'h00, 8'h00, 8'h10}; run_frame(fr, 2'b11, "d_ch0");
    fr = '{8'h53, 8'h01, 8'h07, 8'h00}; run_frame(fr, 2'b11, "d_badty");

    // Stalled frame: timeout fires after TOB bit periods, not before.
    e0 = n_ferr;
    send_byte(8'h53, 2'b11, 1'b1);
    send_byte(8'h01, 2'b11, 1'b1);
    repeat (30 * D3) @(negedge clk);
    chk("to_early", 64'(n_ferr - e0), 64'(0));
    repeat (12 * D3) @(negedge clk);
    chk("to_fire", 64'(n_ferr - e0), 64'(1));
    fr = '{8'h00, 8'h00, 8'h00, 8'h00}; run_frame(fr, 2'b11, "to_hunt");

    // Bad stop bit mid-frame.
    r0 = n_rxv; e0 = n_ferr;
    send_byte(8'h53, 2'b11, 1'b1);
    send_byte(8'h02, 2'b11, 1'b0);
    chk("stop_nrx", 64'(n_rxv - r0), 64'(1));
    chk("stop_err", 64'(n_ferr - e0), 64'(1));
    fr = '{8'h53, 8'h03, 8'h02, 8'h55}; run_frame(fr, 2'b11, "stop_rec");

    // Short glitch on rx.
    r0 = n_rxv; e0 = n_ferr;
    baud = 2'b11;
    @(negedge clk); rx = 1'b0;
    repeat (3) @(negedge clk); rx = 1'b1;
    repeat (3 * D3) @(negedge clk);
    chk("glitch_nrx", 64'(n_rxv - r0), 64'(0));
    chk("glitch_err", 64'(n_ferr - e0), 64'(0));

    // Randomized frames at mixed rates.
    for (int n = 0; n < 25; n++) begin
      int kind;
      logic [1:0] bd;
      kind  = int'($urandom_range(0, 9));
      fr[0] = 8'h53;
      fr[1] = 8'($urandom_range(0, N_CH - 1));
      fr[2] = 8'($urandom_range(0, 2));
      fr[3] = 8'($urandom_range(0, 255));
      if (kind == 7) fr[1] = 8'($urandom_range(N_CH, 255));
      if (kind == 8) fr[2] = 8'($urandom_range(3, 255));
      if (kind == 9) begin
        fr[0] = 8'($urandom_range(0, 255));
        if (fr[0] == 8'h53) fr[0] = 8'h00;
      end
      bd = 2'($urandom_range(1, 3));
      run_frame(fr, bd, $sformatf("rnd%0d", n));
    end

    // Reset during the data bits of a value byte.
    send_byte(8'h53, 2'b11, 1'b1);
    send_byte(8'h03, 2'b11, 1'b1);
    send_byte(8'h02, 2'b11, 1'b1);
    @(negedge clk); rx = 1'b0;
    repeat (D3) @(negedge clk);
    rx = 1'b1; repeat (D3) @(negedge clk);
    rx = 1'b0; repeat (D3) @(negedge clk);
    nrst = 1'b0;
    #1;
    model_reset();
    check_reset_outs("mrst");
    rx = 1'b1;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outs("mrst_rel");
    fr = '{8'h53, 8'h03, 8'h02, 8'hAA}; run_frame(fr, 2'b11, "mrst_fr");

    echo_test();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard stop if something wedges far beyond the expected run length.
  initial begin
    #5000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end
endmodule

// File: doc/uart_trig_cmd.md
# uart_trig_cmd

Parametrised UART command receiver for the trigger-control path. It receives 8N1 bytes at one of four selectable baud rates and parses 4-byte command frames (0x53, channel, type, value) into per-channel trigger registers for N_CH channels. It flags malformed frames, recovers from stalled frames with an inter-byte timeout, and can echo every received byte back on tx through a FIFO. It sits between the host UART pins and the trigger/comparator logic.

## Interface
- N_CH, 4: number of trigger channels (1..16); channel byte must be < N_CH
- DIV0, 109091: clk cycles per bit for baud=00 (110 Bd @ 12 MHz)
- DIV1, 20000: clk cycles per bit for baud=01 (600 Bd)
- DIV2, 5000: clk cycles per bit for baud=10 (2400 Bd)
- DIV3, 1250: clk cycles per bit for baud=11 (9600 Bd)
- TIMEOUT_BITS, 40: bit periods without a byte before a partial frame is abandoned
- FIFO_DEPTH, 8: echo FIFO entries, power of 2, ≥2
- Divisor counters are 20 bits wide; all DIVx are < 2^20 and ≥ 4.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- baud  in  2  rate select, latched at each start-bit detection
- rx  in  1  serial input, asynchronous, idle high
- tx  out  1  serial output, idle high
- trig_val  out  N_CH*8  channel c value at [8c+7:8c]
- trig_type  out  N_CH*2  channel c type at [2c+1:2c]
- trig_upd  out  N_CH  one-cycle pulse on the channel just written
- rx_byte  out  8  last received byte
- rx_valid  out  1  one-cycle pulse, rx_byte valid
- frame_err  out  1  one-cycle pulse on any parse, stop-bit or timeout error
- echo_ovf  out  1  one-cycle pulse when an echo byte is dropped
- busy  out  1  RX not idle, TX active, or FIFO non-empty

## Operation
- Reset values: tx=1, trig_val=0, trig_type=2'b11 (disabled) on every channel, trig_upd=0, rx_byte=0, rx_valid=0, frame_err=0, echo_ovf=0, busy=0; parser in HUNT; FIFO empty.
- RX synchroniser: two flops on rx; all logic uses the synchronised signal.
- RX FSM: IDLE → START on a falling edge, divisor latched from baud. START waits DIV/2; if line high → IDLE (glitch, no error). Else DATA: 8 samples spaced DIV, LSB first. STOP: sample after DIV; 1 → rx_byte updated, rx_valid pulse; 0 → frame_err pulse, byte discarded, parser → HUNT. Return to IDLE.
- Parser FSM on each rx_valid: HUNT: 0x53 → CH, anything else ignored (no error). CH: byte < N_CH → latch channel, TYPE; else frame_err, HUNT. TYPE: byte ≤ 2 → latch type, VAL; else frame_err, HUNT. VAL: trig_val[ch] ← byte, trig_type[ch] ← latched type, trig_upd[ch] pulse, → HUNT.
- Timeout: in CH/TYPE/VAL, counter of bit periods since last rx_valid; reaching TIMEOUT_BITS → frame_err, HUNT. An active RX byte does not reset the counter; its rx_valid does.
- 0x53 received in CH/TYPE/VAL is treated as ordinary data, not a resync.
- TX: when idle and FIFO non-empty, pop and send start, 8 data LSB first, one stop bit, each DIV cycles using the baud value latched at pop.

## Timing
- rx_valid asserts 1 cycle after the mid-stop-bit sample: about 2 + DIV/2 + 9·DIV cycles after the rx falling edge.
- trig_upd and the new trig_val/trig_type are visible in the cycle after the rx_valid of the value byte; frame_err for a bad byte asserts in that same cycle.
- FIFO push in the rx_valid cycle; pop/TX start no earlier than 1 cycle later. Full with a simultaneous pop: push accepted. Full without a pop: byte dropped, echo_ovf pulses.
- A baud change mid-byte has no effect until the next start bit or pop.
- nrst asserted mid-operation: immediate return to reset values, partial frame and FIFO contents lost.

## Configuration
- UART_TRIG_ECHO_EN defined: echo FIFO and TX are present as described.
- Not defined: no FIFO/TX logic; tx tied 1, echo_ovf tied 0, busy reflects RX only.

## Test plan
- baud=11, send 53 02 01 7F → trig_upd[2] one pulse, trig_val[23:16]=0x7F, trig_type[5:4]=01; other channels unchanged.
- N_CH=4, send 53 05 → frame_err pulse on the 0x05 rx_valid; next 53 00 00 10 updates channel 0 to 0x10.
- Send 53 01, then idle 40 bit periods → frame_err pulse; then 00 → no update (parser in HUNT).
- Byte with stop bit 0 mid-frame → frame_err, no rx_valid; a 1/3-bit rx glitch → no rx_valid and no error.
- ECHO_EN, baud=10, 10 back-to-back bytes with tx held busy → tx replays bytes in order, echo_ovf pulses for overflow bytes only.
- Assert nrst during DATA of the value byte → all outputs at reset values; the next full frame is accepted.
